multi_debouncer: RTL and testbench
==================================

Name: multi_debouncer

Overview:
- Parametrised N-channel switch debouncer; successor to the single-channel debouncer driven by the existing directed bench.
- Each channel synchronises a raw switch input, filters bounce with a per-channel stability counter, and produces a debounced level plus a one-cycle rising-edge tick.
- Adds a global enable and an optional falling-edge tick.
- Sits between board-level switch/button pins and control logic.

Parameters:
- N_CH, 4, number of independent channels.
- CNT_W, 20, stability counter width in bits.
- STABLE_CYCLES, 1000000, consecutive stable synchronised samples required to accept a new level; must satisfy 1 <= STABLE_CYCLES <= 2^CNT_W.
- SYNC_STAGES, 2, synchroniser flop depth per channel; must be >= 2.

Ports:
- clk_i  input  1  system clock, all logic on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- en_i  input  1  global filter enable.
- sw_i  input  N_CH  raw asynchronous switch inputs.
- db_level_o  output  N_CH  debounced level per channel.
- db_tick_o  output  N_CH  one-cycle pulse on accepted 0->1 transition.
- db_fall_o  output  N_CH  one-cycle pulse on accepted 1->0 transition; only present with DEBOUNCE_FALL_TICK_EN.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - synchroniser flops, counters and all outputs are 0;
  - every channel FSM is in ZERO;
  - release is synchronous to clk_i via normal flop behaviour.
- Synchroniser: sw_sync[k] is sw_i[k] delayed by SYNC_STAGES flops.
- Per-channel FSM states: ZERO, WAIT1, ONE, WAIT0. Channels are fully independent.
- ZERO:
  - if sw_sync=1, go to WAIT1 with cnt=0.
- WAIT1:
  - if sw_sync=0, return to ZERO with cnt=0 (bounce rejected, no output change);
  - else if cnt==STABLE_CYCLES-1, go to ONE;
  - else cnt++.
- ONE, WAIT0: mirror images of ZERO, WAIT1 with polarity inverted.
- db_level_o[k]: registered; 1 in ONE and WAIT0, 0 in ZERO and WAIT1. Changes on the same edge that enters ONE or ZERO from a WAIT state.
- db_tick_o[k]: registered; high for exactly the first cycle of ONE entered from WAIT1. Never asserted on reset exit.
- Latency: a clean edge on sw_i is reflected on db_level_o and db_tick_o SYNC_STAGES+STABLE_CYCLES+1 cycles later. Pulses shorter than STABLE_CYCLES sync samples produce no output activity.
- Counter rules:
  - cnt saturates logically at STABLE_CYCLES-1 (transition taken, cnt cleared);
  - no wrap-around possible under the parameter constraint;
  - STABLE_CYCLES=1 gives one WAIT cycle.
- en_i low:
  - WAIT1 returns to ZERO; WAIT0 returns to ONE; cnt cleared;
  - ZERO and ONE hold, db_level_o holds;
  - no ticks;
  - synchronisers keep running.
- en_i rising: filtering restarts from the current stable state. A level differing from db_level_o needs a full STABLE_CYCLES window.
- Simultaneous ticks on multiple channels are allowed.
- Reset asserted mid-WAIT: immediate clear, no tick emitted.

Optional Feature:
- Macro DEBOUNCE_FALL_TICK_EN.
- Defined:
  - db_fall_o port exists;
  - pulses high for exactly the first cycle of ZERO entered from WAIT0;
  - same latency as db_tick_o;
  - 0 during reset and when en_i is low.
- Undefined: port and its logic are absent; all other behaviour is identical.

Decomposition:
- Package debounce_pkg:
  - typedef enum logic [1:0] db_state_e {ZERO, WAIT1, ONE, WAIT0};
  - localparam constants for default CNT_W and SYNC_STAGES.
- Sub-module debounce_ch: one channel (synchroniser, counter, FSM, registered outputs), parametrised by CNT_W, STABLE_CYCLES and SYNC_STAGES.
- multi_debouncer instantiates debounce_ch N_CH times in a generate loop.

Test Plan (bench uses N_CH=4, CNT_W=8, STABLE_CYCLES=8, SYNC_STAGES=2, en_i=1 unless stated):
1. Reset: hold rst_ni=0 with sw_i=4'hF -> db_level_o=0, db_tick_o=0; after release and 20 cycles, level 4'hF with exactly one tick per channel.
2. Clean press: sw_i[0] 0->1 held 20 cycles -> db_tick_o[0] high for 1 cycle exactly 11 cycles after the edge; db_level_o[0]=1 from that cycle; other channels stay 0.
3. Bounce: sw_i[1] toggled with high widths 3,5,7 cycles and low gaps 2 cycles, then low -> db_level_o[1]=0 throughout, no tick.
4. Release: sw_i[0] 1->0 held -> db_level_o[0]=0 11 cycles later, no db_tick_o; with DEBOUNCE_FALL_TICK_EN, db_fall_o[0] pulses 1 cycle on that same cycle.
5. Concurrent channels: sw_i 4'b0000->4'b1010 in the same cycle -> db_tick_o=4'b1010 as a single 1-cycle pulse 11 cycles later.
6. Enable/reset mid-wait:
   - en_i=0 for 2 cycles starting 4 cycles into ch2's wait -> tick arrives 8 sync cycles after en_i returns high, not before;
   - rst_ni asserted mid-wait -> outputs 0 immediately, no tick.

Source files
------------

// File: rtl/debounce_pkg.sv
// ============================================================================
// Module   : debounce_pkg
// Purpose  : Shared state encoding and default sizing for the switch debouncer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package debounce_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_e;

  localparam int unsigned c_DEF_N_CH          = 4;
  localparam int unsigned c_DEF_CNT_W         = 20;
  localparam int unsigned c_DEF_STABLE_CYCLES = 1000000;
  localparam int unsigned c_DEF_SYNC_STAGES   = 2;

endpackage

`default_nettype wire

// File: rtl/debounce_ch.sv
// ============================================================================
// Module   : debounce_ch
// Purpose  : One debouncer channel: synchroniser, stability counter, level FSM.
//            DEBOUNCE_FALL_TICK_EN adds the db_fall_o falling-edge pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_ch
  import debounce_pkg::*;
#(
  parameter int unsigned CNT_W         = c_DEF_CNT_W,
  parameter int unsigned STABLE_CYCLES = c_DEF_STABLE_CYCLES,
  parameter int unsigned SYNC_STAGES   = c_DEF_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic sw_i,
  output logic db_level_o,
  output logic db_tick_o
`ifdef DEBOUNCE_FALL_TICK_EN
  ,
  output logic db_fall_o
`endif
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_sw_sync;
  logic [CNT_W-1:0]       r_cnt;
  db_state_e              r_state;
  logic                   r_level;
  logic                   r_tick;
`ifdef DEBOUNCE_FALL_TICK_EN
  logic                   r_fall;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sw_i};
    end
  end

  assign w_sw_sync = r_sync[SYNC_STAGES-1];

  // Level only moves on a WAIT->stable transition; a rejected bounce
  // falls back to the stable state without touching the outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ZERO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_tick  <= 1'b0;
`ifdef DEBOUNCE_FALL_TICK_EN
      r_fall  <= 1'b0;
`endif
    end else begin
      r_tick <= 1'b0;
`ifdef DEBOUNCE_FALL_TICK_EN
      r_fall <= 1'b0;
`endif
      if (!en_i) begin
        r_cnt <= '0;
        if (r_state == WAIT1) begin
          r_state <= ZERO;
        end else if (r_state == WAIT0) begin
          r_state <= ONE;
        end
      end else begin
        unique case (r_state)
          ZERO: begin
            if (w_sw_sync) begin
              r_state <= WAIT1;
              r_cnt   <= '0;
            end
          end
          WAIT1: begin
            if (!w_sw_sync) begin
              r_state <= ZERO;
              r_cnt   <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
              r_state <= ONE;
              r_cnt   <= '0;
              r_level <= 1'b1;
              r_tick  <= 1'b1;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          ONE: begin
            if (!w_sw_sync) begin
              r_state <= WAIT0;
              r_cnt   <= '0;
            end
          end
          WAIT0: begin
            if (w_sw_sync) begin
              r_state <= ONE;
              r_cnt   <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
              r_state <= ZERO;
              r_cnt   <= '0;
              r_level <= 1'b0;
`ifdef DEBOUNCE_FALL_TICK_EN
              r_fall  <= 1'b1;
`endif
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_state <= ZERO;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign db_level_o = r_level;
  assign db_tick_o  = r_tick;
`ifdef DEBOUNCE_FALL_TICK_EN
  assign db_fall_o  = r_fall;
`endif

endmodule

`default_nettype wire

// File: rtl/multi_debouncer.sv
// ============================================================================
// Module   : multi_debouncer
// Purpose  : N_CH independent switch debouncers with a shared enable.
//            DEBOUNCE_FALL_TICK_EN adds the db_fall_o falling-edge pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module multi_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned N_CH          = c_DEF_N_CH,
  parameter int unsigned CNT_W         = c_DEF_CNT_W,
  parameter int unsigned STABLE_CYCLES = c_DEF_STABLE_CYCLES,
  parameter int unsigned SYNC_STAGES   = c_DEF_SYNC_STAGES
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [N_CH-1:0] sw_i,
  output logic [N_CH-1:0] db_level_o,
  output logic [N_CH-1:0] db_tick_o
`ifdef DEBOUNCE_FALL_TICK_EN
  ,
  output logic [N_CH-1:0] db_fall_o
`endif
);

  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
      debounce_ch #(
        .CNT_W         (CNT_W),
        .STABLE_CYCLES (STABLE_CYCLES),
        .SYNC_STAGES   (SYNC_STAGES)
      ) u_ch (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .en_i       (en_i),
        .sw_i       (sw_i[k]),
        .db_level_o (db_level_o[k]),
        .db_tick_o  (db_tick_o[k])
`ifdef DEBOUNCE_FALL_TICK_EN
        ,
        .db_fall_o  (db_fall_o[k])
`endif
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_multi_debouncer.sv
// ============================================================================
// Module   : tb_multi_debouncer
// Purpose  : Self-checking bench for multi_debouncer (4 channels, 8-cycle window).
//            Honours DEBOUNCE_FALL_TICK_EN for the db_fall_o checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multi_debouncer;

  localparam int N_CH   = 4;
  localparam int CNT_W  = 8;
  localparam int STABLE = 8;
  localparam int SYNC   = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [N_CH-1:0] sw;
  logic [N_CH-1:0] db_level;
  logic [N_CH-1:0] db_tick;
`ifdef DEBOUNCE_FALL_TICK_EN
  logic [N_CH-1:0] db_fall;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference: a level flips once the synchronised input has disagreed with
  // it for STABLE+1 consecutive enabled samples.
  logic [N_CH-1:0] m_level, m_tick, m_fall;
  int              m_run[N_CH];
  logic [N_CH-1:0] m_pipe[$];

  typedef struct {
    logic            rst_n;
    logic            en;
    logic [N_CH-1:0] sw;
    int              cycles;
    logic [N_CH-1:0] exp_level;
    logic [N_CH-1:0] exp_tick;
  } vec_t;

  vec_t tbl[11];

  multi_debouncer #(
    .N_CH          (N_CH),
    .CNT_W         (CNT_W),
    .STABLE_CYCLES (STABLE),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .en_i       (en),
    .sw_i       (sw),
    .db_level_o (db_level),
    .db_tick_o  (db_tick)
`ifdef DEBOUNCE_FALL_TICK_EN
    ,
    .db_fall_o  (db_fall)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [N_CH-1:0] act, input logic [N_CH-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_level = '0;
    m_tick  = '0;
    m_fall  = '0;
    for (int k = 0; k < N_CH; k++) m_run[k] = 0;
    m_pipe = {};
    repeat (SYNC) m_pipe.push_back('0);
  endtask

  task automatic model_step();
    logic [N_CH-1:0] s;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s = m_pipe.pop_front();
    m_pipe.push_back(sw);
    m_tick = '0;
    m_fall = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (!en || s[k] == m_level[k]) begin
        m_run[k] = 0;
      end else begin
        m_run[k]++;
        if (m_run[k] == STABLE + 1) begin
          m_run[k]   = 0;
          m_level[k] = s[k];
          if (s[k]) m_tick[k] = 1'b1;
          else      m_fall[k] = 1'b1;
        end
      end
    end
  endtask

  // One clock: model advances on the edge, DUT compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model_level", db_level, m_level);
    check("model_tick", db_tick, m_tick);
`ifdef DEBOUNCE_FALL_TICK_EN
    check("model_fall", db_fall, m_fall);
`endif
  endtask

  task automatic bounce_hold(input logic v, input int n);
    sw[1] = v;
    for (int i = 0; i < n; i++) begin
      step();
      check("bounce_quiet", {2'b00, db_level[1], db_tick[1]}, 4'b0000);
    end
  endtask

  initial begin
    int           tcnt[N_CH];
    logic [N_CH-1:0] ok;
    logic [N_CH-1:0] seen;

    rst_n = 1'b0;
    en    = 1'b1;
    sw    = 4'hF;
    model_reset();

    // Reset with all switches high, then release.
    repeat (3) step();
    check("rst_level", db_level, 4'h0);
    check("rst_tick", db_tick, 4'h0);
    rst_n = 1'b1;
    for (int k = 0; k < N_CH; k++) tcnt[k] = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      for (int k = 0; k < N_CH; k++) if (db_tick[k]) tcnt[k]++;
    end
    check("rst_exit_level", db_level, 4'hF);
    for (int k = 0; k < N_CH; k++) ok[k] = (tcnt[k] == 1);
    check("rst_exit_one_tick", ok, 4'hF);

    // Table of phases: drive, hold, then compare the end state.
    tbl[0]  = '{1'b0, 1'b1, 4'hF, 3,  4'h0, 4'h0};
    tbl[1]  = '{1'b1, 1'b1, 4'hF, 20, 4'hF, 4'h0};
    tbl[2]  = '{1'b1, 1'b1, 4'h0, 20, 4'h0, 4'h0};
    tbl[3]  = '{1'b1, 1'b0, 4'hF, 20, 4'h0, 4'h0};
    tbl[4]  = '{1'b1, 1'b1, 4'hF, 9,  4'hF, 4'hF};
    tbl[5]  = '{1'b1, 1'b1, 4'hF, 1,  4'hF, 4'h0};
    tbl[6]  = '{1'b1, 1'b1, 4'h0, 20, 4'h0, 4'h0};
    tbl[7]  = '{1'b1, 1'b1, 4'h1, 8,  4'h0, 4'h0};
    tbl[8]  = '{1'b1, 1'b1, 4'h0, 20, 4'h0, 4'h0};
    tbl[9]  = '{1'b1, 1'b1, 4'h1, 9,  4'h0, 4'h0};
    tbl[10] = '{1'b1, 1'b1, 4'h0, 2,  4'h1, 4'h1};
    for (int v = 0; v < 11; v++) begin
      rst_n = tbl[v].rst_n;
      en    = tbl[v].en;
      sw    = tbl[v].sw;
      repeat (tbl[v].cycles) step();
      check($sformatf("tbl%0d_level", v), db_level, tbl[v].exp_level);
      check($sformatf("tbl%0d_tick", v), db_tick, tbl[v].exp_tick);
    end
    rst_n = 1'b1;
    en    = 1'b1;
    sw    = 4'h0;
    repeat (20) step();

    // Clean press on channel 0.
    sw = 4'b0001;
    for (int i = 1; i <= 20; i++) begin
      step();
      check("press_tick", db_tick, (i == 11) ? 4'b0001 : 4'b0000);
      check("press_level", db_level, (i >= 11) ? 4'b0001 : 4'b0000);
    end

    // Bounce on channel 1: 3/5/7-cycle highs with 2-cycle gaps.
    bounce_hold(1'b1, 3);
    bounce_hold(1'b0, 2);
    bounce_hold(1'b1, 5);
    bounce_hold(1'b0, 2);
    bounce_hold(1'b1, 7);
    bounce_hold(1'b0, 20);

    // Release on channel 0.
    sw[0] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      step();
      check("release_level", db_level, (i < 11) ? 4'b0001 : 4'b0000);
      check("release_no_tick", db_tick, 4'b0000);
`ifdef DEBOUNCE_FALL_TICK_EN
      check("release_fall", db_fall, (i == 11) ? 4'b0001 : 4'b0000);
`endif
    end

    // Two channels pressed on the same cycle.
    sw = 4'b1010;
    for (int i = 1; i <= 20; i++) begin
      step();
      check("concurrent_tick", db_tick, (i == 11) ? 4'b1010 : 4'b0000);
    end

    // Enable dropped for two cycles four cycles into channel 2's wait.
    sw = 4'b1110;
    for (int i = 1; i <= 25; i++) begin
      step();
      check("en_gap_tick", db_tick, (i == 18) ? 4'b0100 : 4'b0000);
      check("en_gap_level", db_level, (i >= 18) ? 4'b1110 : 4'b1010);
      if (i == 7) en = 1'b0;
      if (i == 9) en = 1'b1;
    end

    // Asynchronous reset while channel 3 is waiting to fall.
    sw = 4'b0110;
    repeat (5) step();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_level", db_level, 4'h0);
    check("async_rst_tick", db_tick, 4'h0);
    repeat (2) step();
    sw    = 4'h0;
    rst_n = 1'b1;
    seen  = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      seen |= db_tick;
    end
    check("post_rst_no_tick", seen, 4'h0);

    // Randomised traffic against the reference model.
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < N_CH; k++)
        if ($urandom_range(0, 11) == 0) sw[k] = ~sw[k];
      en    = ($urandom_range(0, 19) != 0);
      rst_n = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
